periph_bus_arbiter: RTL and testbench

Two-master round-robin arbiter for the memory-mapped peripheral bus: it shares one slave port, such as the GPIO bank at 0xA000 or any peripheral with the same addr/wdata/wmask/wen/ren/rdata/ready signalling, between master 0 (CPU) and master 1 (DMA/sequencer). It serialises whole transactions, holds the grant until the slave signals `ready`, and alternates ownership on contention. An optional watchdog aborts transactions whose slave never responds.

---
 rtl/periph_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter sharing one peripheral slave port.
// Optional slave watchdog compiled in with `define PERIPH_ARB_TIMEOUT_EN.
module periph_bus_arbiter #(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_wen,
  input  logic        m0_ren,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_wen,
  input  logic        m1_ren,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_wen,
  output logic        s_ren,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   last, last_nxt;
  logic   req0, req1, own_req, winner;

  assign req0    = m0_wen | m0_ren;
  assign req1    = m1_wen | m1_ren;
  assign own_req = owner ? req1 : req0;
  // On a tie the master that was not granted last wins.
  assign winner  = (req0 & req1) ? ~last : req1;

`ifdef PERIPH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  logic          wd_expire;

  assign wd_expire = (wd_cnt == CW'(TIMEOUT - 1)) & ~s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wd_cnt <= '0;
    else if (state != BUSY)         wd_cnt <= '0;
    else if (!s_ready)              wd_cnt <= wd_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              err <= 1'b0;
    else if (state == ABORT) err <= 1'b1;
    else if (err_clr)        err <= 1'b0;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nxt = BUSY;
          owner_nxt = winner;
          last_nxt  = winner;
        end
      end
      BUSY: begin
        // Completion or abandonment both return to IDLE for one cycle.
        if (s_ready || !own_req) state_nxt = IDLE;
`ifdef PERIPH_ARB_TIMEOUT_EN
        else if (wd_expire)      state_nxt = ABORT;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_addr   = '0;
    s_wdata  = '0;
    s_wmask  = '0;
    s_wen    = 1'b0;
    s_ren    = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    unique case (state)
      BUSY: begin
        s_addr  = owner ? m1_addr  : m0_addr;
        s_wdata = owner ? m1_wdata : m0_wdata;
        s_wmask = owner ? m1_wmask : m0_wmask;
        s_wen   = owner ? m1_wen   : m0_wen;
        s_ren   = owner ? m1_ren   : m0_ren;
        if (owner) begin
          m1_ready = s_ready & own_req;
          m1_rdata = s_rdata;
        end else begin
          m0_ready = s_ready & own_req;
          m0_rdata = s_rdata;
        end
      end
`ifdef PERIPH_ARB_TIMEOUT_EN
      ABORT: begin
        // Strobes withdrawn from the slave; owner gets the error word.
        s_addr  = owner ? m1_addr  : m0_addr;
        s_wdata = owner ? m1_wdata : m0_wdata;
        s_wmask = owner ? m1_wmask : m0_wmask;
        if (owner) begin
          m1_ready = 1'b1;
          m1_rdata = ERR_RDATA;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = ERR_RDATA;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomized and directed bench for periph_bus_arbiter against a bus-ownership model.
module tb_periph_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a[2], wd[2];
  logic [3:0]  wm[2];
  logic        we[2], re[2];
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [31:0] s_rdata = '0;
  logic [3:0]  s_wmask;
  logic        m0_ready, m1_ready, s_wen, s_ren, err;
  logic        s_ready = 1'b0;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  periph_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(a[0]), .m0_wdata(wd[0]), .m0_wmask(wm[0]), .m0_wen(we[0]), .m0_ren(re[0]),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_addr(a[1]), .m1_wdata(wd[1]), .m1_wmask(wm[1]), .m1_wen(we[1]), .m1_ren(re[1]),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_wen(s_wen), .s_ren(s_ren),
    .s_rdata(s_rdata), .s_ready(s_ready), .err(err), .err_clr(err_clr)
  );

  int n_chk = 0, n_fail = 0;
  // Model: who holds the bus (-1 = nobody) and who won the last grant.
  int cur = -1, prev = 1;
  bit done0, done1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic new_req(input bit k);
    a[k]  = $urandom;
    wd[k] = $urandom;
    wm[k] = 4'($urandom_range(0, 15));
    case ($urandom_range(0, 2))
      0: begin we[k] = 1'b1; re[k] = 1'b0; end
      1: begin we[k] = 1'b0; re[k] = 1'b1; end
      default: begin we[k] = 1'b1; re[k] = 1'b1; end
    endcase
  endtask

  task automatic clear_reqs();
    we[0] = 1'b0; re[0] = 1'b0; we[1] = 1'b0; re[1] = 1'b0;
    a[0] = '0; a[1] = '0; wd[0] = '0; wd[1] = '0; wm[0] = '0; wm[1] = '0;
  endtask

  task automatic check_model();
    logic [69:0] sb;
    logic [31:0] rd0, rd1;
    logic        r0, r1;
    bit          o;
    #1;
    sb = '0; rd0 = '0; rd1 = '0; r0 = 1'b0; r1 = 1'b0;
    if (cur >= 0) begin
      o  = cur[0];
      sb = {a[o], wd[o], wm[o], we[o], re[o]};
      if (o) begin r1 = s_ready; rd1 = s_rdata; end
      else   begin r0 = s_ready; rd0 = s_rdata; end
    end
    chk("s_bus",   128'({s_addr, s_wdata, s_wmask, s_wen, s_ren}), 128'(sb));
    chk("m_ready", 128'({m1_ready, m0_ready}), 128'({r1, r0}));
    chk("m_rdata", 128'({m1_rdata, m0_rdata}), 128'({rd1, rd0}));
    chk("err",     128'(err), 128'(0));
  endtask

  task automatic advance();
    bit q0, q1;
    q0 = we[0] | re[0];
    q1 = we[1] | re[1];
    if (cur < 0) begin
      if (q0 | q1) begin
        cur  = (q0 && q1) ? 1 - prev : (q0 ? 0 : 1);
        prev = cur;
      end
    end else if (s_ready) begin
      if (cur == 0) done0 = 1'b1; else done1 = 1'b1;
      cur = -1;
    end
    @(posedge clk);
    @(negedge clk);
    if (done0) begin we[0] = 1'b0; re[0] = 1'b0; done0 = 1'b0; end
    if (done1) begin we[1] = 1'b0; re[1] = 1'b0; done1 = 1'b0; end
  endtask

  task automatic cyc();
    check_model();
    advance();
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 128'({s_addr, s_wdata, s_wmask, s_wen, s_ren}), 128'(0));
    chk(tag, 128'({m0_rdata, m1_rdata, m0_ready, m1_ready, err}), 128'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cur = -1; prev = 1; done0 = 1'b0; done1 = 1'b0;
    clear_reqs();
    s_ready = 1'b0; s_rdata = '0; err_clr = 1'b0;
    @(negedge clk);
    #1 chk_all_zero("rst_out");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ngr, nrise, bw;
    bit g;
    clear_reqs();

    // Single read with the slave always ready
    do_reset();
    s_ready = 1'b1; s_rdata = 32'h0000_00A5;
    a[0] = 32'hA008; re[0] = 1'b1;
    cyc();
    check_model();
    chk("rd_addr",  128'(s_addr), 128'(32'hA008));
    chk("rd_ready", 128'(m0_ready), 128'(1));
    chk("rd_data",  128'(m0_rdata), 128'(32'hA5));
    chk("rd_m1",    128'(m1_ready), 128'(0));
    advance();
    cyc();

    // Tie after reset: m0 first, IDLE, then m1 even when m0 re-requests
    do_reset();
    s_ready = 1'b1;
    a[0] = 32'hA004; wd[0] = 32'h1234; wm[0] = 4'hF; we[0] = 1'b1;
    a[1] = 32'hA000; wd[1] = 32'hFFFF; wm[1] = 4'hF; we[1] = 1'b1;
    cyc();
    check_model(); chk("tie_c2", 128'({m1_ready, m0_ready}), 128'(2'b01)); advance();
    a[0] = 32'hA004; wd[0] = 32'h1234; wm[0] = 4'hF; we[0] = 1'b1;
    check_model(); chk("tie_c3", 128'({m1_ready, m0_ready, s_wen}), 128'(0)); advance();
    check_model(); chk("tie_c4", 128'({m1_ready, m0_ready}), 128'(2'b10));
    chk("tie_c4_addr", 128'(s_addr), 128'(32'hA000)); advance();
    cyc(); cyc(); cyc();

    // Back-to-back contention: grants alternate starting with m0
    do_reset();
    s_ready = 1'b1; ngr = 0;
    for (int c = 0; c < 100 && ngr < 16; c++) begin
      if (!(we[0] | re[0])) new_req(1'b0);
      if (!(we[1] | re[1])) new_req(1'b1);
      s_rdata = $urandom;
      check_model();
      if (m0_ready | m1_ready) begin
        g = m1_ready;
        chk("alt_grant", 128'(g), 128'(ngr % 2));
        chk("alt_wmask", 128'(s_wmask), 128'(wm[g]));
        ngr++;
      end
      advance();
    end
    chk("alt_count", 128'(ngr), 128'(16));
    clear_reqs();
    cyc();

    // Slow slave: ready only in BUSY cycle 6, m1 stays pending
    do_reset();
    new_req(1'b0); new_req(1'b1);
    cyc();
    nrise = 0;
    for (int b = 1; b <= 6; b++) begin
      s_ready = (b == 6);
      check_model();
      chk("slow_m0", 128'(m0_ready), 128'(b == 6));
      chk("slow_m1", 128'(m1_ready), 128'(0));
      if (m0_ready) nrise++;
      advance();
    end
    s_ready = 1'b1;
    check_model(); if (m0_ready) nrise++; advance();
    check_model(); chk("slow_m1_served", 128'(m1_ready), 128'(1)); advance();
    chk("slow_once", 128'(nrise), 128'(1));
    cyc();

    // Randomized traffic
    do_reset();
    bw = 0;
    for (int c = 0; c < 400; c++) begin
      if (!(we[0] | re[0]) && $urandom_range(0, 9) < 6) new_req(1'b0);
      if (!(we[1] | re[1]) && $urandom_range(0, 9) < 6) new_req(1'b1);
      s_ready = ($urandom_range(0, 9) < 7) || (bw >= 8);
      s_rdata = $urandom;
      bw = (cur >= 0 && !s_ready) ? bw + 1 : 0;
      cyc();
    end

    // Reset pulsed in BUSY cycle 3, then the held request completes
    do_reset();
    s_ready = 1'b0; s_rdata = 32'h5A5A_0001;
    a[0] = 32'hA00C; re[0] = 1'b1;
    cyc(); cyc(); cyc();
    check_model();
    chk("mid_busy", 128'(s_ren), 128'(1));
    #1 rst_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    cur = -1; prev = 1;
    @(negedge clk);
    rst_n = 1'b1;
    s_ready = 1'b1;
    cyc();
    check_model(); chk("rst_redo", 128'(m0_ready), 128'(1)); advance();
    cyc();

    // Watchdog on a slave that never responds
    do_reset();
    s_ready = 1'b0; s_rdata = 32'h1111_2222;
    a[1] = 32'hA010; re[1] = 1'b1;
    cyc();
`ifdef PERIPH_ARB_TIMEOUT_EN
    for (int b = 1; b <= 16; b++) cyc();
    #1;
    chk("wd_ready", 128'(m1_ready), 128'(1));
    chk("wd_rdata", 128'(m1_rdata), 128'(32'hDEAD_BEEF));
    chk("wd_ren",   128'(s_ren), 128'(0));
    @(posedge clk); @(negedge clk);
    re[1] = 1'b0; cur = -1;
    #1 chk("wd_err", 128'(err), 128'(1));
    @(negedge clk); @(negedge clk);
    #1 chk("wd_err_hold", 128'(err), 128'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1 chk("wd_err_clr", 128'(err), 128'(0));
`else
    for (int b = 1; b <= 100; b++) cyc();
    #1;
    chk("wd_waiting", 128'({m1_ready, s_ren}), 128'(2'b01));
    err_clr = 1'b1;
    #1 chk("wd_err_off", 128'(err), 128'(0));
    err_clr = 1'b0;
    @(negedge clk);
    s_ready = 1'b1;
    cyc(); cyc();
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
